mem_line_bank: RTL and testbench

Parametrised bank of NLINES recirculating drum long lines, with write gating, early-bus read-out, command-line select register and a drum-position timer. It generalises the fixed seven-line memory into one block with variable line count and geometry. It adds a post-reset clear sweep so that every output has a defined value, and it sits between the timing/decoder logic and the early bus / command-path logic.

---
 rtl/g15_mem_pkg.sv | 65 ++++++
 rtl/mem_line_bank_if.sv | 47 ++++
 rtl/mem_line_bank_drum_track.sv | 18 +
 rtl/mem_line_bank.sv | 128 ++++++++++++
 tb/tb_mem_line_bank.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/g15_mem_pkg.sv
// Shared defaults, CD priority encoding and command-code decode for the drum line bank.
package g15_mem_pkg;

    localparam int WORD_BITS_DEF = 29;
    localparam int WORDS_DEF     = 108;
    localparam int TRACK_LEN_DEF = WORD_BITS_DEF * WORDS_DEF;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bank_state_e;

    // Ordered highest priority first.
    typedef enum logic [2:0] {
        CD_OP_CLEAR = 3'd0,
        CD_OP_ONES  = 3'd1,
        CD_OP_LOAD  = 3'd2,
        CD_OP_TYPE  = 3'd3,
        CD_OP_HOLD  = 3'd4
    } cd_op_e;

    typedef enum logic [1:0] {
        SEL_LINE  = 2'd0,
        SEL_EXT_A = 2'd1,
        SEL_EXT_B = 2'd2,
        SEL_ONE   = 2'd3
    } cmd_src_e;

    typedef struct packed {
        cmd_src_e   src;
        logic [3:0] line;
    } cmd_sel_t;

    function automatic cd_op_e cd_priority(input logic clr, input logic ones,
                                           input logic load, input logic typ);
        if (clr)       return CD_OP_CLEAR;
        else if (ones) return CD_OP_ONES;
        else if (load) return CD_OP_LOAD;
        else if (typ)  return CD_OP_TYPE;
        else           return CD_OP_HOLD;
    endfunction

    // The two top codes always mean the external short lines, even if a
    // mis-sized CDW would let them alias a long-line index.
    function automatic cmd_sel_t cmd_decode(input logic [7:0] code, input int nlines,
                                            input int cdw);
        cmd_sel_t sel;
        int       c;
        int       top;
        c        = int'(code);
        top      = (1 << cdw) - 1;
        sel.src  = SEL_ONE;
        sel.line = '0;
        if (c == top) begin
            sel.src = SEL_EXT_B;
        end else if (c == top - 1) begin
            sel.src = SEL_EXT_A;
        end else if (c < nlines) begin
            sel.src  = SEL_LINE;
            sel.line = 4'(c);
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_line_bank_if.sv
// Signal bundle between the timing/decoder logic (master) and the line bank (slave).
interface mem_line_bank_if
    import g15_mem_pkg::*;
#(
    parameter int NLINES    = 8,
    parameter int CDW       = 3,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int WORDS     = WORDS_DEF
);
    localparam int LW  = $clog2(NLINES);
    localparam int BTW = $clog2(WORD_BITS);
    localparam int WTW = $clog2(WORDS);

    logic              lb;
    logic              wr_en;
    logic [LW-1:0]     wr_line;
    logic              rd_en;
    logic [LW-1:0]     rd_line;
    logic              ext_a;
    logic              ext_b;
    logic [CDW-1:0]    cd_d;
    logic              cd_load;
    logic              type_load;
    logic [CDW-1:0]    type_sel;
    logic              tape_start;
    logic              cd_clear;
    logic [NLINES-1:0] m;
    logic              eb;
    logic [CDW-1:0]    cd;
    logic              mc_n;
    logic [BTW-1:0]    bit_time;
    logic [WTW-1:0]    word_time;
    logic              busy;

    modport master (
        output lb, wr_en, wr_line, rd_en, rd_line, ext_a, ext_b,
               cd_d, cd_load, type_load, type_sel, tape_start, cd_clear,
        input  m, eb, cd, mc_n, bit_time, word_time, busy
    );

    modport slave (
        input  lb, wr_en, wr_line, rd_en, rd_line, ext_a, ext_b,
               cd_d, cd_load, type_load, type_sel, tape_start, cd_clear,
        output m, eb, cd, mc_n, bit_time, word_time, busy
    );

endinterface

// File: rtl/mem_line_bank_drum_track.sv
// One recirculating drum track: a bit entering on i_d leaves on o_q N cycles later.
// No reset and no backpressure; contents are defined by the bank's clear sweep.
module drum_track #(
    parameter int N = 16
) (
    input  logic clk,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_sr;

    always_ff @(posedge clk) begin
        r_sr <= {r_sr[N-2:0], i_d};
    end

    assign o_q = r_sr[N-1];

endmodule

// File: rtl/mem_line_bank.sv
// Bank of NLINES drum long lines with write gating, early-bus read, CD select register and position timer.
// Track latency TRACK_LEN cycles, outputs combinational from track taps; no backpressure.
module mem_line_bank
    import g15_mem_pkg::*;
#(
    parameter int NLINES    = 8,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int WORDS     = WORDS_DEF,
    parameter int CDW       = 3
) (
    input  logic CLOCK,
    input  logic rst,
    mem_line_bank_if.slave bus
);
    localparam int TRACK_LEN = WORD_BITS * WORDS;
    localparam int LW        = $clog2(NLINES);
    localparam int BTW       = $clog2(WORD_BITS);
    localparam int WTW       = $clog2(WORDS);
    localparam logic [BTW-1:0] BT_LAST = BTW'(WORD_BITS - 1);
    localparam logic [WTW-1:0] WT_LAST = WTW'(WORDS - 1);

    bank_state_e       r_state;
    bank_state_e       w_state_nxt;
    logic              w_clearing;
    logic [BTW-1:0]    r_bit_time;
    logic [WTW-1:0]    r_word_time;
    logic [CDW-1:0]    r_cd;
    logic [CDW-1:0]    w_cd_nxt;
    logic              w_rev_end;
    logic [NLINES-1:0] w_trk_in;
    logic [NLINES-1:0] w_trk_out;
    logic [NLINES-1:0] w_m;
    logic              w_eb;
    logic              w_sel_bit;
    cmd_sel_t          w_sel;

    assign w_rev_end = (r_bit_time == BT_LAST) && (r_word_time == WT_LAST);

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) r_state <= ST_CLEAR;
        else      r_state <= w_state_nxt;
    end

    // The sweep ends exactly when the counters wrap back to address 0.
    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing = 1'b1;
                if (w_rev_end) w_state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            r_bit_time  <= '0;
            r_word_time <= '0;
            r_cd        <= '0;
        end else begin
            r_cd <= w_cd_nxt;
            if (r_bit_time == BT_LAST) begin
                r_bit_time  <= '0;
                r_word_time <= (r_word_time == WT_LAST) ? '0 : r_word_time + 1'b1;
            end else begin
                r_bit_time <= r_bit_time + 1'b1;
            end
        end
    end

    always_comb begin
        w_cd_nxt = r_cd;
        case (cd_priority(bus.cd_clear, bus.tape_start, bus.cd_load, bus.type_load))
            CD_OP_CLEAR: w_cd_nxt = '0;
            CD_OP_ONES:  w_cd_nxt = '1;
            CD_OP_LOAD:  w_cd_nxt = bus.cd_d;
            CD_OP_TYPE:  w_cd_nxt = bus.type_sel;
            default:     ;
        endcase
    end

    for (genvar gi = 0; gi < NLINES; gi++) begin : g_line
        assign w_trk_in[gi] = w_clearing ? 1'b0 :
                              (bus.wr_en && (bus.wr_line == LW'(gi))) ? bus.lb :
                              w_trk_out[gi];
        drum_track #(.N(TRACK_LEN)) u_track (
            .clk (CLOCK),
            .i_d (w_trk_in[gi]),
            .o_q (w_trk_out[gi])
        );
    end

    assign w_m   = w_clearing ? '0 : w_trk_out;
    assign w_sel = cmd_decode(8'(r_cd), NLINES, CDW);

    // Out-of-range line numbers match no index and read as 0.
    always_comb begin
        w_eb = 1'b0;
        for (int i = 0; i < NLINES; i++) begin
            if (bus.rd_line == LW'(i)) w_eb = w_m[i];
        end
        w_eb = w_eb & bus.rd_en;

        w_sel_bit = 1'b1;
        case (w_sel.src)
            SEL_LINE: begin
                w_sel_bit = 1'b0;
                for (int i = 0; i < NLINES; i++) begin
                    if (w_sel.line == 4'(i)) w_sel_bit = w_m[i];
                end
            end
            SEL_EXT_A: w_sel_bit = bus.ext_a;
            SEL_EXT_B: w_sel_bit = bus.ext_b;
            default:   w_sel_bit = 1'b1;
        endcase
    end

    assign bus.m         = w_m;
    assign bus.eb        = w_eb;
    assign bus.cd        = r_cd;
    assign bus.mc_n      = ~w_clearing & ~w_sel_bit;
    assign bus.bit_time  = r_bit_time;
    assign bus.word_time = r_word_time;
    assign bus.busy      = w_clearing;

endmodule

// File: tb/tb_mem_line_bank.sv
// Bench for mem_line_bank: drum-address reference model compared every cycle, plus directed literal checks.
module tb_mem_line_bank;
    import g15_mem_pkg::*;

    localparam int NL = 4;
    localparam int WB = 4;
    localparam int WD = 4;
    localparam int CW = 3;
    localparam int TL = WB * WD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_line_bank_if #(.NLINES(NL), .CDW(CW), .WORD_BITS(WB), .WORDS(WD)) bus ();

    mem_line_bank #(.NLINES(NL), .WORD_BITS(WB), .WORDS(WD), .CDW(CW)) dut (
        .CLOCK (clk),
        .rst   (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: drum address p (0..TL-1) and per-address track contents.
    int       p     = 0;
    bit       mbusy = 1'b1;
    bit [2:0] mcd   = 3'd0;
    bit       mem [NL][TL];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: evaluates the model for the current cycle at the falling edge,
    // then advances the model past the coming rising edge.
    initial begin
        logic [NL-1:0] em;
        logic          eeb;
        logic          emc;
        int            code;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p     = 0;
                mbusy = 1'b1;
                mcd   = 3'd0;
            end
            for (int i = 0; i < NL; i++) em[i] = mbusy ? 1'b0 : mem[i][p];
            eeb  = bus.rd_en & em[bus.rd_line];
            code = int'(mcd);
            if (mbusy)                  emc = 1'b0;
            else if (code < NL)         emc = ~em[code];
            else if (code == (1 << CW) - 2) emc = ~bus.ext_a;
            else if (code == (1 << CW) - 1) emc = ~bus.ext_b;
            else                        emc = 1'b0;

            chk("busy",      32'(bus.busy),      32'(mbusy));
            chk("bit_time",  32'(bus.bit_time),  32'(p % WB));
            chk("word_time", 32'(bus.word_time), 32'(p / WB));
            chk("m",         32'(bus.m),         32'(em));
            chk("eb",        32'(bus.eb),        32'(eeb));
            chk("cd",        32'(bus.cd),        32'(mcd));
            chk("mc_n",      32'(bus.mc_n),      32'(emc));

            if (rst) begin
                for (int i = 0; i < NL; i++) begin
                    if (mbusy) mem[i][p] = 1'b0;
                    else if (bus.wr_en && int'(bus.wr_line) == i) mem[i][p] = bus.lb;
                end
                if (bus.cd_clear)        mcd = 3'd0;
                else if (bus.tape_start) mcd = 3'd7;
                else if (bus.cd_load)    mcd = bus.cd_d;
                else if (bus.type_load)  mcd = bus.type_sel;
                if (mbusy && p == TL - 1) mbusy = 1'b0;
                p = (p + 1) % TL;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lb = 1'b0;  bus.wr_en = 1'b0; bus.wr_line = '0;
        bus.rd_en = 1'b0; bus.rd_line = '0;
        bus.ext_a = 1'b0; bus.ext_b = 1'b0;
        bus.cd_d = '0; bus.cd_load = 1'b0; bus.type_load = 1'b0; bus.type_sel = '0;
        bus.tape_start = 1'b0; bus.cd_clear = 1'b0;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic [3:0] pat;
        pat = 4'b1011;
        idle();
        rst = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_cd",   32'(bus.cd),   32'd0);
        chk("rst_bt",   32'(bus.bit_time), 32'd0);
        chk("rst_m",    32'(bus.m),    32'd0);
        chk("rst_mc_n", 32'(bus.mc_n), 32'd0);

        tick();
        rst = 1'b1;
        for (int c = 0; c < TL; c++) begin
            #1;
            chk("sweep_busy", 32'(bus.busy), 32'd1);
            chk("sweep_m",    32'(bus.m),    32'd0);
            tick();
        end
        #1;
        chk("run_busy", 32'(bus.busy), 32'd0);
        chk("run_bt",   32'(bus.bit_time), 32'd0);
        chk("run_wt",   32'(bus.word_time), 32'd0);

        // Pattern 1011 into line 2 at word 1.
        repeat (4) tick();
        for (int b = 0; b < WB; b++) begin
            bus.wr_en = 1'b1; bus.wr_line = 2'd2; bus.lb = pat[3-b];
            tick();
        end
        bus.wr_en = 1'b0; bus.lb = 1'b0;
        repeat (TL - WB) tick();
        for (int rev = 0; rev < 2; rev++) begin
            for (int b = 0; b < WB; b++) begin
                #1;
                chk("line2_pat", 32'(bus.m), pat[3-b] ? 32'h4 : 32'h0);
                tick();
            end
            repeat (TL - WB) tick();
        end

        // Write and read line 1 in the same cycle.
        bus.wr_en = 1'b1; bus.wr_line = 2'd1; bus.lb = 1'b1;
        bus.rd_en = 1'b1; bus.rd_line = 2'd1;
        #1;
        chk("wr_rd_old", 32'(bus.eb), 32'd0);
        tick();
        bus.wr_en = 1'b0; bus.lb = 1'b0;
        repeat (TL - 1) tick();
        #1;
        chk("wr_rd_new", 32'(bus.eb), 32'd1);
        tick();
        bus.rd_en = 1'b0;

        // CD priority.
        bus.cd_load = 1'b1; bus.cd_d = 3'd2;
        tick();
        bus.cd_load = 1'b0;
        #1;
        chk("cd_load2", 32'(bus.cd), 32'd2);
        bus.cd_clear = 1'b1; bus.tape_start = 1'b1; bus.cd_load = 1'b1; bus.cd_d = 3'd2;
        #1;
        chk("cd_same_cycle_old", 32'(bus.cd), 32'd2);
        tick();
        bus.cd_clear = 1'b0; bus.cd_load = 1'b0;
        #1;
        chk("cd_clear_wins", 32'(bus.cd), 32'd0);
        tick();
        bus.tape_start = 1'b0;
        #1;
        chk("cd_tape_ones", 32'(bus.cd), 32'd7);
        bus.cd_load = 1'b1; bus.cd_d = 3'd6; bus.ext_a = 1'b1;
        tick();
        bus.cd_load = 1'b0;
        #1;
        chk("cd_load6", 32'(bus.cd), 32'd6);
        chk("mc_n_ext_a1", 32'(bus.mc_n), 32'd0);
        bus.ext_a = 1'b0;
        #1;
        chk("mc_n_ext_a0", 32'(bus.mc_n), 32'd1);

        // Unused code and line 3.
        bus.cd_load = 1'b1; bus.cd_d = 3'd5;
        tick();
        bus.cd_load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.ext_a = 1'($urandom); bus.ext_b = 1'($urandom);
            #1;
            chk("mc_n_unused", 32'(bus.mc_n), 32'd0);
            tick();
        end
        bus.cd_load = 1'b1; bus.cd_d = 3'd3;
        tick();
        bus.cd_load = 1'b0;
        #1;
        chk("mc_n_line3", 32'(bus.mc_n), 32'd1);

        // Reset in RUN at word 2.
        for (int c = 0; c < TL; c++) begin
            if (p / WB == 2) break;
            tick();
        end
        #1;
        chk("pre_rst_wt", 32'(bus.word_time), 32'd2);
        rst = 1'b0;
        #1;
        chk("midrst_cd",   32'(bus.cd), 32'd0);
        chk("midrst_bt",   32'(bus.bit_time), 32'd0);
        chk("midrst_wt",   32'(bus.word_time), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd1);
        tick();
        rst = 1'b1;
        repeat (TL) tick();
        for (int c = 0; c < TL; c++) begin
            #1;
            chk("post_sweep_m", 32'(bus.m), 32'd0);
            tick();
        end

        // Randomised traffic.
        for (int c = 0; c < 900; c++) begin
            bus.lb         = 1'($urandom);
            bus.wr_en      = ($urandom_range(0, 2) == 0);
            bus.wr_line    = 2'($urandom);
            bus.rd_en      = 1'($urandom);
            bus.rd_line    = 2'($urandom);
            bus.ext_a      = 1'($urandom);
            bus.ext_b      = 1'($urandom);
            bus.cd_d       = 3'($urandom);
            bus.type_sel   = 3'($urandom);
            bus.cd_load    = ($urandom_range(0, 5) == 0);
            bus.type_load  = ($urandom_range(0, 5) == 0);
            bus.tape_start = ($urandom_range(0, 15) == 0);
            bus.cd_clear   = ($urandom_range(0, 15) == 0);
            rst            = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1;
        idle();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
